// File: rtl/run_controller.sv
// Run controller: holds a processor in reset, lets it run until it halts or times out,
// and reports run statistics (cycles, retired instructions, final pc).
module run_controller #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 14,
  parameter logic [31:0] HALT_INSN    = 32'h0000_0073,
  parameter int unsigned STALL_LIMIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [31:0]          insn,
  output logic                 core_reset,
  output logic                 running,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [PC_WIDTH-1:0]  last_pc
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] MAX_CYC   = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [7:0]           HOLD_INIT = 8'(RESET_CYCLES);
  localparam logic [7:0]           STALL_LIM = 8'(STALL_LIMIT);

  // Assertion is asynchronous; release reaches the FSM two clock edges later.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  state_e               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic [7:0]           stall_q, stall_d;
  logic                 first_q, first_d;
  logic [PC_WIDTH-1:0]  prev_pc_q, prev_pc_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 halted_q, halted_d;
  logic                 timeout_q, timeout_d;
  logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
  logic                 halt_hit, time_hit;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    hold_d    = hold_q;
    stall_d   = stall_q;
    first_d   = first_q;
    prev_pc_d = prev_pc_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    last_pc_d = last_pc_q;
    halt_hit  = 1'b0;
    time_hit  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cycle_d   = '0;
          retired_d = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          hold_d    = HOLD_INIT;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (hold_q <= 8'd1) begin
          first_d = 1'b1;
          stall_d = '0;
          state_d = RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      RUN: begin
        prev_pc_d = pc;
        first_d   = 1'b0;
        if (cycle_q != CNT_MAX) cycle_d = cycle_q + 1'b1;
        // The first RUN cycle has no previous pc, so it neither retires nor stalls.
        if (!first_q) begin
          if (pc != prev_pc_q) begin
            stall_d = '0;
            if (retired_q != CNT_MAX) retired_d = retired_q + 1'b1;
          end else if (stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
          end
        end
        halt_hit = (insn == HALT_INSN) || (stall_d >= STALL_LIM);
        time_hit = (cycle_d >= MAX_CYC);
        if (halt_hit || time_hit) begin
          halted_d  = halt_hit;
          timeout_d = time_hit;
          last_pc_d = pc;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      stall_q   <= '0;
      first_q   <= 1'b0;
      prev_pc_q <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      last_pc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      hold_q    <= hold_d;
      stall_q   <= stall_d;
      first_q   <= first_d;
      prev_pc_q <= prev_pc_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign core_reset    = (state_q != RUN);
  assign running       = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign halted        = halted_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;
  assign last_pc       = last_pc_q;

endmodule
